// File: rtl/mips8_ext_pkg.sv
// rtl/mips8_ext_pkg.sv - shared types and immediate-extension function for the mips8 extend stage
//
// Contents:
//   MAX_W        widest operand ext_compute can produce
//   ext_mode_t   extension mode selector (sign / zero / shifted-sign / upper)
//   ext_state_t  occupancy of the two-entry output buffer
//   ext_compute  combinational extension; returns {ovf, value} in MAX_W+1 bits
package mips8_ext_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'd0,
        EXT_ZERO  = 2'd1,
        EXT_SHL   = 2'd2,
        EXT_UPPER = 2'd3
    } ext_mode_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } ext_state_t;

    // Widths are passed as run-time ints so one function serves every
    // parameterisation; callers hand in their elaboration constants, which
    // folds all the shifts below down to wiring.
    // Intermediates are 2*MAX_W wide so shifted-sign results and the
    // discarded upper bits can be inspected without losing anything.
    function automatic logic [MAX_W:0] ext_compute(
        input logic [MAX_W-1:0] imm,
        input ext_mode_t        mode,
        input int               in_w,
        input int               out_w,
        input int               shift
    );
        logic [2*MAX_W-1:0] ones;
        logic [2*MAX_W-1:0] wide;
        logic [2*MAX_W-1:0] sext;
        logic [2*MAX_W-1:0] s;
        logic [2*MAX_W-1:0] shl;
        logic [2*MAX_W-1:0] out_mask;
        logic [2*MAX_W-1:0] disc;
        logic [2*MAX_W-1:0] disc_mask;
        logic [MAX_W-1:0]   res;
        logic               sign;
        logic               msb;
        logic               ovf;

        ones     = '1;
        wide     = {{MAX_W{1'b0}}, imm};
        sign     = ((wide >> (in_w - 1)) & 64'd1) != 64'd0;
        sext     = sign ? (wide | (ones << in_w)) : wide;
        out_mask = ~(ones << out_w);

        // s is the immediate sign-extended to in_w+shift bits; the shifted
        // product then occupies in_w+2*shift bits.
        s         = sext & ~(ones << (in_w + shift));
        shl       = s << shift;
        disc      = shl >> out_w;
        disc_mask = (~(ones << (in_w + 2 * shift))) >> out_w;
        msb       = ((shl >> (out_w - 1)) & 64'd1) != 64'd0;

        ovf = 1'b0;
        case (mode)
            EXT_SIGN:  res = MAX_W'(sext & out_mask);
            EXT_ZERO:  res = MAX_W'(wide & out_mask);
            EXT_SHL: begin
                res = MAX_W'(shl & out_mask);
                // Truncation is lossless only if every dropped bit copies
                // the new sign bit.
                ovf = (disc != (msb ? disc_mask : {2*MAX_W{1'b0}}));
            end
            default:   res = MAX_W'((wide << (out_w - in_w)) & out_mask);
        endcase

        return {ovf, res};
    endfunction

endpackage

// File: rtl/imm_ext_skid.sv
// rtl/imm_ext_skid.sv - generic two-entry valid/ready skid buffer
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready is registered)
//   in_data[W]            upstream payload
//   out_valid/out_ready   downstream handshake
//   out_data[W]           downstream payload, always the oldest item
module imm_ext_skid
    import mips8_ext_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    ext_state_t   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         accept;
    logic         drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = ST_TWO;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so no accept can coincide.
                if (drain) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Registered from next state so in_ready never sees out_ready combinationally.
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - registered immediate-extension stage with skid buffering
//
// Parameters: IN_W immediate width, OUT_W result width, SHIFT left shift in EXT_SHL.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     producer handshake
//   in_imm[IN_W]          raw immediate
//   in_mode[2]            ext_mode_t selector, latched with each item
//   out_valid/out_ready   consumer handshake
//   out_value[OUT_W]      extended operand
//   out_ovf               truncation flag (EXT_SHL only)
module imm_extend_unit
    import mips8_ext_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int OUT_W = 8,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic             out_ovf
);

    if (IN_W < 2 || IN_W > OUT_W) begin : g_bad_in_w
        $error("imm_extend_unit: IN_W must be in 2..OUT_W");
    end
    if (SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_shift
        $error("imm_extend_unit: SHIFT must be in 0..OUT_W-1");
    end
    if (OUT_W > MAX_W) begin : g_bad_out_w
        $error("imm_extend_unit: OUT_W exceeds MAX_W");
    end

    logic [MAX_W-1:0] imm_wide;
    logic [MAX_W:0]   ext_res;
    logic [OUT_W:0]   skid_in;
    logic [OUT_W:0]   skid_out;

    always_comb begin
        imm_wide             = '0;
        imm_wide[IN_W-1:0]   = in_imm;
    end

    assign ext_res = ext_compute(imm_wide, ext_mode_t'(in_mode), IN_W, OUT_W, SHIFT);
    assign skid_in = {ext_res[MAX_W], ext_res[OUT_W-1:0]};

    if (OUT_W < MAX_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^ext_res[MAX_W-1:OUT_W];
    end

    imm_ext_skid #(
        .W(OUT_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (skid_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out)
    );

    assign out_value = skid_out[OUT_W-1:0];
    assign out_ovf   = skid_out[OUT_W];

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - self-checking bench for imm_extend_unit
module tb_imm_extend_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_imm;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_value;
    logic       out_ovf;

    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] out_value2;
    logic       out_ovf2;

    int n_checks;
    int n_fail;

    imm_extend_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_ovf   (out_ovf)
    );

    imm_extend_unit #(.IN_W(6), .OUT_W(8), .SHIFT(3)) dut_sh3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid2),
        .out_ready (1'b1),
        .out_value (out_value2),
        .out_ovf   (out_ovf2)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent arithmetic model for IN_W=6, OUT_W=8.
    function automatic logic [8:0] model(input logic [5:0] imm, input logic [1:0] mode, input int sh);
        int         v;
        int         p;
        logic [7:0] val;
        logic       ovf;
        v   = int'(imm);
        if (imm[5]) v = v - 64;
        ovf = 1'b0;
        case (mode)
            2'd0: val = 8'(v);
            2'd1: val = {2'b00, imm};
            2'd2: begin
                p   = v * (1 << sh);
                val = 8'(p);
                ovf = (p < -128) || (p > 127);
            end
            default: val = {imm, 2'b00};
        endcase
        return {ovf, val};
    endfunction

    typedef struct {
        logic [1:0] mode;
        logic [5:0] imm;
        bit         sh3;
        logic [7:0] val;
        logic       ovf;
    } vec_t;

    vec_t vecs[9];

    logic [8:0] sb[$];
    logic       hold_v;
    logic [8:0] hold_d;
    logic       acc;
    logic       have;
    logic [5:0] pimm;
    logic [1:0] pmode;

    // Called at a falling edge: drives one cycle, checks, then waits for the next falling edge.
    task automatic step(input logic v, input logic [5:0] imm, input logic [1:0] mode,
                        input logic ordy, output logic accepted);
        logic       rdy0;
        logic       ordy0;
        logic [8:0] e;
        in_valid = v;
        in_imm   = imm;
        in_mode  = mode;
        rdy0     = in_ready;
        ordy0    = out_ready;
        out_ready = ordy;
        #1;
        if (ordy0 !== ordy) chk("in_ready_comb_path", in_ready, rdy0);
        if (hold_v && out_valid) chk("stall_stable", {out_ovf, out_value}, hold_d);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%0h, expected no item", {out_ovf, out_value});
            end else begin
                e = sb.pop_front();
                chk("out_item", {out_ovf, out_value}, e);
            end
        end
        hold_v   = out_valid && !out_ready;
        hold_d   = {out_ovf, out_value};
        accepted = in_valid && in_ready;
        if (accepted) sb.push_back(model(imm, mode, 2));
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        hold_v    = 1'b0;
        hold_d    = '0;

        vecs[0] = '{2'd0, 6'h25, 1'b0, 8'hE5, 1'b0};
        vecs[1] = '{2'd0, 6'h15, 1'b0, 8'h15, 1'b0};
        vecs[2] = '{2'd1, 6'h25, 1'b0, 8'h25, 1'b0};
        vecs[3] = '{2'd1, 6'h3F, 1'b0, 8'h3F, 1'b0};
        vecs[4] = '{2'd2, 6'h3F, 1'b0, 8'hFC, 1'b0};
        vecs[5] = '{2'd2, 6'h20, 1'b0, 8'h80, 1'b0};
        vecs[6] = '{2'd3, 6'h25, 1'b0, 8'h94, 1'b0};
        vecs[7] = '{2'd2, 6'h10, 1'b1, 8'h80, 1'b1};
        vecs[8] = '{2'd2, 6'h08, 1'b1, 8'h40, 1'b0};

        // Reset state
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_value", out_value, 0);
        chk("reset_out_ovf", out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", in_ready, 1);

        // Table vectors: one-cycle latency with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_imm   = vecs[i].imm;
            in_mode  = vecs[i].mode;
            @(negedge clk);
            in_valid = 1'b0;
            if (vecs[i].sh3) begin
                chk($sformatf("vec%0d_valid", i), out_valid2, 1);
                chk($sformatf("vec%0d_value", i), out_value2, vecs[i].val);
                chk($sformatf("vec%0d_ovf", i), out_ovf2, vecs[i].ovf);
            end else begin
                chk($sformatf("vec%0d_valid", i), out_valid, 1);
                chk($sformatf("vec%0d_value", i), out_value, vecs[i].val);
                chk($sformatf("vec%0d_ovf", i), out_ovf, vecs[i].ovf);
            end
            @(negedge clk);
            chk($sformatf("vec%0d_drained", i), out_valid, 0);
        end

        // Backpressure: A, B accepted, C held, then A B C back-to-back
        step(1'b1, 6'h25, 2'd0, 1'b0, acc);
        chk("bp_A_accepted", acc, 1);
        step(1'b1, 6'h3A, 2'd1, 1'b0, acc);
        chk("bp_B_accepted", acc, 1);
        chk("bp_ready_low_after_B", in_ready, 0);
        step(1'b1, 6'h11, 2'd3, 1'b0, acc);
        chk("bp_C_held_1", acc, 0);
        step(1'b1, 6'h11, 2'd3, 1'b0, acc);
        chk("bp_C_held_2", acc, 0);
        chk("bp_out_A_valid", out_valid, 1);
        step(1'b1, 6'h11, 2'd3, 1'b1, acc);
        chk("bp_C_blocked_while_full", acc, 0);
        chk("bp_out_B_valid", out_valid, 1);
        step(1'b1, 6'h11, 2'd3, 1'b1, acc);
        chk("bp_C_accepted", acc, 1);
        chk("bp_out_C_valid", out_valid, 1);
        step(1'b0, 6'h00, 2'd0, 1'b1, acc);
        chk("bp_sb_empty", sb.size(), 0);
        chk("bp_idle_after", out_valid, 0);

        // Reset mid-operation with both entries full
        step(1'b1, 6'h2A, 2'd0, 1'b0, acc);
        step(1'b1, 6'h15, 2'd2, 1'b0, acc);
        chk("rst_full_before", in_ready, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_out_value", out_value, 0);
        chk("rst_async_in_ready", in_ready, 0);
        chk("rst_async_out_ovf", out_ovf, 0);
        #1;
        rst_n = 1'b1;
        sb.delete();
        hold_v = 1'b0;
        @(negedge clk);
        chk("rst_ready_after_release", in_ready, 1);
        chk("rst_no_stale_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'h00, 2'd0, 1'b1, acc);
            chk("rst_no_stale_item", out_valid, 0);
        end

        // Random stress against the scoreboard
        have  = 1'b0;
        pimm  = '0;
        pmode = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!have && ($urandom_range(0, 99) < 60)) begin
                have  = 1'b1;
                pimm  = 6'($urandom);
                pmode = 2'($urandom);
            end
            step(have, pimm, pmode, ($urandom_range(0, 99) < 55), acc);
            if (acc) have = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 6'h00, 2'd0, 1'b1, acc);
        end
        chk("stress_sb_empty", sb.size(), 0);
        chk("stress_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Registered, parametrised immediate-extension stage for the mips8 datapath. It sits between instruction decode and the ALU/branch-target operand mux. It widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, shifted-sign (branch offset) and upper (LUI-style). A valid/ready handshake with a two-entry skid buffer lets decode stall without losing operands, and the block flags truncation in shifted-sign mode.

## Interface
- IN_W, default 6: immediate width; legal range 2..OUT_W.
- OUT_W, default 8: extended operand width.
- SHIFT, default 2: left shift applied in EXT_SHL mode; legal range 0..OUT_W-1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low; clears all state.
- in_valid  in  1  producer holds imm/mode valid.
- in_ready  out  1  block can accept; registered output; reset value 0, then 1 in the first cycle after release.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  ext_mode_t selector.
- out_valid  out  1  out_value/out_ovf valid; reset value 0.
- out_ready  in  1  consumer accepts.
- out_value  out  OUT_W  extended result; reset value 0.
- out_ovf  out  1  EXT_SHL truncation flag; reset value 0; 0 in all other modes.

## Operation
- Transfer in: in_valid && in_ready at the clock edge. Transfer out: out_valid && out_ready at the clock edge.
- EXT_SIGN (0): replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W.
- EXT_ZERO (1): fill the upper bits with 0.
- EXT_SHL (2): form s = sign-extend of in_imm to IN_W+SHIFT bits. Then:
  - out_value = s shifted left by SHIFT, truncated to OUT_W.
  - out_ovf = 1 when the discarded upper bits are not all equal to out_value[OUT_W-1].
  - With the defaults, out_ovf is never set.
- EXT_UPPER (3): out_value = in_imm placed in bits OUT_W-1..OUT_W-IN_W, with the low bits 0.
- Result and flag are computed combinationally from the input and captured at the accept edge. Mode is latched per item.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main register full, out_valid=1, in_ready=1.
  - TWO: main and skid registers full, out_valid=1, in_ready=0.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on drain with no accept.
  - ONE→ONE on simultaneous accept and drain; the main register takes the new item.
  - ONE→TWO on accept with no drain; the new item goes to the skid register.
  - TWO→ONE on drain; the skid register moves to main.
- Items are delivered strictly in order; none are dropped or duplicated.
- in_valid while in_ready=0 is ignored. The producer must hold the item.
- rst_n asserted mid-operation: all buffered items are discarded, and outputs return to their reset values immediately (asynchronously).

## Timing
- Latency is 1 cycle: an item accepted at edge N is presented from edge N with out_valid=1 in cycle N+1.
- Throughput is 1 item/cycle when out_ready is held high.
- in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.
- out_value and out_ovf hold stable while out_valid=1 and out_ready=0.

## Structure
- Package mips8_ext_pkg holds:
  - typedef ext_mode_t: EXT_SIGN=2'd0, EXT_ZERO=2'd1, EXT_SHL=2'd2, EXT_UPPER=2'd3.
  - typedef ext_state_t for EMPTY/ONE/TWO.
  - Function ext_compute(imm, mode), parametrised through its callers.
- Sub-module imm_ext_skid: generic 2-entry valid/ready skid buffer, width OUT_W+1 (value plus ovf). The top level is ext_compute feeding imm_ext_skid.
- Elaboration-time checks: IN_W <= OUT_W and SHIFT < OUT_W.

## Test plan
- Defaults, out_ready=1:
  - EXT_SIGN imm 0x25 → 0xE5; imm 0x15 → 0x15.
  - EXT_ZERO imm 0x25 → 0x25.
  - Each result appears one cycle after accept.
- Defaults, EXT_SHL: imm 0x3F → 0xFC, ovf 0; imm 0x20 → 0x80, ovf 0.
  - EXT_UPPER: imm 0x25 → 0x94.
- IN_W=6, OUT_W=8, SHIFT=3, EXT_SHL: imm 0x10 → 0x80, ovf 1; imm 0x08 → 0x40, ovf 0.
- Backpressure:
  - Offer items A, B, C back-to-back with out_ready=0. A and B are accepted; in_ready drops after B; C is held.
  - Raise out_ready. A, B, C emerge in order over 3 consecutive cycles with no gap.
- Reset mid-operation: in state TWO, pulse rst_n low between edges.
  - Immediately: out_valid=0, out_value=0, in_ready=0.
  - First cycle after release: in_ready=1; no stale items emerge.
- Random stress: random in_valid/out_ready over 10k cycles against a scoreboard model. Required: in-order, lossless delivery; out_value stable while stalled; in_ready never depends combinationally on out_ready.
